// File: rtl/sprite_palette_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_palette_pkg
// Description : Shared types and constants for the sprite palette bank.
//               Holds the 4:4:4 RGB entry type, the power-on contents of
//               palette bank 0, and the default transparent (key) index.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_palette_pkg;

  // One 4:4:4 palette entry; r occupies the top nibble, matching {R,G,B}.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int DEFAULT_ENTRIES = 16;
  localparam int KEY_IDX_DEFAULT = 0;

  // Bank 0 contents after reset. Entries 6..15 repeat the key colour A/E/A.
  localparam rgb_t DEFAULT_PAL [DEFAULT_ENTRIES] = '{
    12'hAEA, 12'hA01, 12'hFFF, 12'h000, 12'hF76, 12'h050, 12'hAEA, 12'hAEA,
    12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA
  };

endpackage : sprite_palette_pkg
`default_nettype wire

// File: rtl/palette_frame_latch.sv
`default_nettype none
// ============================================================================
// Module      : palette_frame_latch
// Description : Pending/active register pair. Requests are held as pending
//               (last one wins) and promoted to active only on frame_start,
//               so a frame is never recoloured part-way. A request arriving
//               together with frame_start is applied at that same pulse.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_frame_start     - one-cycle promotion pulse
//               i_req/i_req_valid - new request (already range-checked)
//               o_active          - value in force for the current frame
// Revision    : 1.0 - initial release
// ============================================================================
module palette_frame_latch #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_frame_start,
  input  logic [W-1:0] i_req,
  input  logic         i_req_valid,
  output logic [W-1:0] o_active
);

  logic [W-1:0] r_pend;
  logic         r_pend_v;
  logic [W-1:0] r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_active <= '0;
    end else if (i_frame_start) begin
      // A same-cycle request is newer than anything pending, so it wins.
      if (i_req_valid) begin
        r_active <= i_req;
      end else if (r_pend_v) begin
        r_active <= r_pend;
      end
      r_pend_v <= 1'b0;
    end else if (i_req_valid) begin
      r_pend   <= i_req;
      r_pend_v <= 1'b1;
    end
  end

  assign o_active = r_active;

endmodule : palette_frame_latch
`default_nettype wire

// File: rtl/sprite_palette_bank.sv
`default_nettype none
// ============================================================================
// Module      : sprite_palette_bank
// Description : Multi-bank, runtime-writable sprite palette. Maps a colour
//               index to CH_W-bit RGB plus a transparency flag through a
//               fixed 2-cycle pipeline. Bank and dim level switch only on
//               frame_start.
// Ports       : Clk, Reset                  - pixel clock, sync reset
//               pix_valid, index            - pixel lookup request
//               frame_start                 - vertical blank pulse
//               bank_req(_valid)            - requested palette bank
//               dim_req(_valid)             - requested right-shift 0..3
//               wr_en, wr_bank, wr_index,
//               wr_rgb                      - palette entry write port
//               red, green, blue,
//               transparent, out_valid      - pipelined pixel output
//               active_bank                 - bank in use this frame
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int KEY_IDX   = KEY_IDX_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  index,
  input  logic              frame_start,
  input  logic [BANK_W-1:0] bank_req,
  input  logic              bank_req_valid,
  input  logic [1:0]        dim_req,
  input  logic              dim_req_valid,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_rgb,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  output logic              out_valid,
  output logic [BANK_W-1:0] active_bank
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int RGB_W   = 3 * CH_W;

  // Expand a 4:4:4 default entry to CH_W-bit channels, MSB-aligned so the
  // default colours keep their brightness for wider channels.
  function automatic logic [RGB_W-1:0] f_default(input int bank, input int idx);
    rgb_t             p;
    logic [11:0]      pv;
    logic [RGB_W-1:0] v;
    v = '0;
    if (bank == 0) begin
      p  = (idx < DEFAULT_ENTRIES) ? DEFAULT_PAL[idx] : DEFAULT_PAL[6];
      pv = p;
      for (int c = 0; c < 3; c++) begin
        for (int b = 0; b < 4; b++) begin
          if (b < CH_W) begin
            v[c*CH_W + CH_W-1-b] = pv[c*4 + 3-b];
          end
        end
      end
    end
    return v;
  endfunction

  logic [RGB_W-1:0]  r_mem [NUM_BANKS][ENTRIES];
  logic              w_bank_ok;
  logic              w_wr_ok;
  logic [BANK_W-1:0] w_active_bank;
  logic [1:0]        w_dim;

  // Out-of-range banks are dropped before they reach the latch/storage.
  assign w_bank_ok = bank_req_valid && ({1'b0, bank_req} < (BANK_W+1)'(NUM_BANKS));
  assign w_wr_ok   = wr_en && ({1'b0, wr_bank} < (BANK_W+1)'(NUM_BANKS));

  palette_frame_latch #(.W(BANK_W)) u_bank_latch (
    .clk          (Clk),
    .rst          (Reset),
    .i_frame_start(frame_start),
    .i_req        (bank_req),
    .i_req_valid  (w_bank_ok),
    .o_active     (w_active_bank)
  );

  palette_frame_latch #(.W(2)) u_dim_latch (
    .clk          (Clk),
    .rst          (Reset),
    .i_frame_start(frame_start),
    .i_req        (dim_req),
    .i_req_valid  (dim_req_valid),
    .o_active     (w_dim)
  );

  // Palette storage. Reads in the pipeline see the pre-write value on a
  // same-cycle write to the same entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          r_mem[b][e] <= f_default(b, e);
        end
      end
    end else if (w_wr_ok) begin
      r_mem[wr_bank][wr_index] <= wr_rgb;
    end
  end

  logic [RGB_W-1:0] r_s1_rgb;
  logic             r_s1_t;
  logic             r_s1_v;
  logic [1:0]       r_s1_dim;
  logic [CH_W-1:0]  w_s1_r;
  logic [CH_W-1:0]  w_s1_g;
  logic [CH_W-1:0]  w_s1_b;
  logic [CH_W-1:0]  r_red;
  logic [CH_W-1:0]  r_green;
  logic [CH_W-1:0]  r_blue;
  logic             r_transparent;
  logic             r_out_valid;

  assign w_s1_r = r_s1_rgb[3*CH_W-1 -: CH_W];
  assign w_s1_g = r_s1_rgb[2*CH_W-1 -: CH_W];
  assign w_s1_b = r_s1_rgb[CH_W-1   -: CH_W];

  // Stage 1 uses the bank/dim registered before any frame_start update in
  // the same cycle; the dim travels with the pixel into stage 2.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_rgb      <= '0;
      r_s1_t        <= 1'b0;
      r_s1_v        <= 1'b0;
      r_s1_dim      <= '0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_transparent <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_s1_rgb      <= r_mem[w_active_bank][index];
      r_s1_t        <= (index == IDX_W'(KEY_IDX));
      r_s1_v        <= pix_valid;
      r_s1_dim      <= w_dim;
      r_red         <= w_s1_r >> r_s1_dim;
      r_green       <= w_s1_g >> r_s1_dim;
      r_blue        <= w_s1_b >> r_s1_dim;
      r_transparent <= r_s1_t;
      r_out_valid   <= r_s1_v;
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign transparent = r_transparent;
  assign out_valid   = r_out_valid;
  assign active_bank = w_active_bank;

endmodule : sprite_palette_bank
`default_nettype wire

// File: tb/tb_sprite_palette_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_palette_bank
// Description : Self-checking bench for sprite_palette_bank. Expected pixel
//               results are queued when a pixel is driven and compared when
//               the design presents output; control state is checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [3:0]  index = '0;
  logic        frame_start = 1'b0;
  logic [1:0]  bank_req = '0;
  logic        bank_req_valid = 1'b0;
  logic [1:0]  dim_req = '0;
  logic        dim_req_valid = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic [3:0]  red, green, blue;
  logic        transparent, out_valid;
  logic [1:0]  active_bank;

  // Second instance with three banks for the out-of-range request case.
  logic [1:0]  d3_bank_req = '0;
  logic        d3_bank_req_valid = 1'b0;
  logic        d3_frame_start = 1'b0;
  logic [3:0]  d3_red, d3_green, d3_blue;
  logic        d3_transparent, d3_out_valid;
  logic [1:0]  d3_active_bank;

  always #5 Clk = ~Clk;

  sprite_palette_bank dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .index(index),
    .frame_start(frame_start), .bank_req(bank_req), .bank_req_valid(bank_req_valid),
    .dim_req(dim_req), .dim_req_valid(dim_req_valid), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .out_valid(out_valid), .active_bank(active_bank)
  );

  sprite_palette_bank #(.NUM_BANKS(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .pix_valid(1'b0), .index(4'd0),
    .frame_start(d3_frame_start), .bank_req(d3_bank_req),
    .bank_req_valid(d3_bank_req_valid), .dim_req(2'd0), .dim_req_valid(1'b0),
    .wr_en(1'b0), .wr_bank(2'd0), .wr_index(4'd0), .wr_rgb(12'd0),
    .red(d3_red), .green(d3_green), .blue(d3_blue), .transparent(d3_transparent),
    .out_valid(d3_out_valid), .active_bank(d3_active_bank)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        t;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0]  idx;
    logic [11:0] rgb;
    logic        t;
  } vec_t;

  exp_t q[$];
  int   cycles = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge Clk) cycles <= cycles + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, wanted $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cycles);
    end
  endtask

  // Scoreboard: compare the output against the oldest queued expectation.
  task automatic monitor();
    logic exp_v;
    while (q.size() > 0 && q[0].due < cycles) begin
      check("missing_output", 32'(0), 32'(1));
      void'(q.pop_front());
    end
    exp_v = (q.size() > 0) && (q[0].due == cycles);
    if (exp_v || out_valid) begin
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v && out_valid) begin
        check("rgb", 32'({red, green, blue}), 32'(q[0].rgb));
        check("transparent", 32'(transparent), 32'(q[0].t));
      end
      if (exp_v) void'(q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge Clk);
    monitor();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    bank_req_valid = 1'b0;
    dim_req_valid = 1'b0;
    wr_en = 1'b0;
    d3_bank_req_valid = 1'b0;
    d3_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pix(input logic [3:0] idx, input logic [11:0] rgb, input logic t);
    exp_t e;
    pix_valid = 1'b1;
    index = idx;
    e.rgb = rgb;
    e.t = t;
    e.due = cycles + 2;
    q.push_back(e);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{4'd0,  12'hAEA, 1'b1};
    vecs[1] = '{4'd1,  12'hA01, 1'b0};
    vecs[2] = '{4'd4,  12'hF76, 1'b0};
    vecs[3] = '{4'd2,  12'hFFF, 1'b0};
    vecs[4] = '{4'd3,  12'h000, 1'b0};
    vecs[5] = '{4'd5,  12'h050, 1'b0};
    vecs[6] = '{4'd6,  12'hAEA, 1'b0};
    vecs[7] = '{4'd15, 12'hAEA, 1'b0};

    @(negedge Clk);
    step();
    check("reset_outputs", 32'({red, green, blue, transparent, out_valid, active_bank}), 32'(0));
    Reset = 1'b0;
    step();

    // Default bank 0 lookups, back to back.
    for (int i = 0; i < 8; i++) begin
      pix(vecs[i].idx, vecs[i].rgb, vecs[i].t);
      step();
    end
    idle(3);

    // Write bank 1, request it mid-frame: bank 0 stays in force until frame_start.
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd2; wr_rgb = 12'hC39;
    step();
    bank_req = 2'd1; bank_req_valid = 1'b1;
    step();
    pix(4'd2, 12'hFFF, 1'b0);
    step();
    check("bank_hold_midframe", 32'(active_bank), 32'(0));
    idle(3);
    frame_start = 1'b1;
    step();
    check("bank_after_fs", 32'(active_bank), 32'(1));
    pix(4'd2, 12'hC39, 1'b0);
    step();
    idle(3);

    // Last request wins; same-cycle request bypasses.
    bank_req = 2'd2; bank_req_valid = 1'b1;
    step();
    bank_req = 2'd3; bank_req_valid = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    check("bank_last_wins", 32'(active_bank), 32'(3));
    frame_start = 1'b1; bank_req = 2'd1; bank_req_valid = 1'b1;
    step();
    check("bank_bypass", 32'(active_bank), 32'(1));
    frame_start = 1'b1;
    step();
    check("bank_no_pending", 32'(active_bank), 32'(1));
    frame_start = 1'b1; bank_req = 2'd0; bank_req_valid = 1'b1;
    step();

    // Dim levels.
    dim_req = 2'd2; dim_req_valid = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    pix(4'd2, 12'h333, 1'b0);
    step();
    idle(3);
    dim_req = 2'd3; dim_req_valid = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    pix(4'd4, 12'h100, 1'b0);
    step();
    pix(4'd0, 12'h111, 1'b1);
    step();
    idle(3);
    frame_start = 1'b1; dim_req = 2'd0; dim_req_valid = 1'b1;
    step();

    // Read-before-write on the same entry, then new value.
    wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd1; wr_rgb = 12'h555;
    pix(4'd1, 12'hA01, 1'b0);
    step();
    pix(4'd1, 12'h555, 1'b0);
    step();
    // Recolouring the key entry keeps it transparent.
    wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd0; wr_rgb = 12'h123;
    step();
    pix(4'd0, 12'h123, 1'b1);
    step();
    idle(3);

    // Three-bank instance: bank 3 is out of range.
    d3_bank_req = 2'd2; d3_bank_req_valid = 1'b1;
    step();
    d3_frame_start = 1'b1;
    step();
    check("d3_bank2", 32'(d3_active_bank), 32'(2));
    d3_bank_req = 2'd3; d3_bank_req_valid = 1'b1;
    step();
    d3_frame_start = 1'b1;
    step();
    check("d3_bank3_dropped", 32'(d3_active_bank), 32'(2));
    d3_frame_start = 1'b1; d3_bank_req = 2'd3; d3_bank_req_valid = 1'b1;
    step();
    check("d3_bank3_bypass_dropped", 32'(d3_active_bank), 32'(2));

    // Reset with pixels in flight and non-default bank/dim/pending state.
    frame_start = 1'b1; bank_req = 2'd2; bank_req_valid = 1'b1;
    dim_req = 2'd1; dim_req_valid = 1'b1;
    step();
    check("bank_pre_reset", 32'(active_bank), 32'(2));
    bank_req = 2'd3; bank_req_valid = 1'b1;
    step();
    pix(4'd1, 12'h000, 1'b0);
    step();
    Reset = 1'b1;
    pix_valid = 1'b1; index = 4'd1;
    q.delete();
    step();
    check("reset_kills_pipe", 32'(out_valid), 32'(0));
    check("reset_bank", 32'(active_bank), 32'(0));
    Reset = 1'b0;
    step();
    check("reset_kills_pipe2", 32'(out_valid), 32'(0));
    frame_start = 1'b1;
    step();
    check("reset_clears_pending", 32'(active_bank), 32'(0));
    pix(4'd1, 12'hA01, 1'b0);
    step();
    pix(4'd0, 12'hAEA, 1'b1);
    step();
    idle(4);
    check("scoreboard_drained", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sprite_palette_bank
`default_nettype wire

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
Runtime-reloadable, multi-bank sprite palette. It maps a per-pixel colour index from sprite ROM readout to 4:4:4 RGB plus a transparency flag, through a fixed 2-cycle pipeline.
- Bank select and dim level change only at frame start, so a frame is never recoloured part-way.
- A write port lets game logic recolour sprites, e.g. damage flash or team colours.
- Sits between the sprite ROM address/readout stage and the VGA colour mux.

Parameters:
- IDX_W, 4, colour index width; entries per bank = 2**IDX_W.
- CH_W, 4, bits per colour channel.
- NUM_BANKS, 4, number of palettes; need not be a power of two.
- BANK_W, 2, bank select width; must be >= clog2(NUM_BANKS).
- KEY_IDX, 0, index treated as transparent in every bank.

Ports:
- Clk  in  1  pixel-domain clock.
- Reset  in  1  synchronous, active-high.
- pix_valid  in  1  index is a live pixel this cycle.
- index  in  IDX_W  colour index to look up.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- bank_req  in  BANK_W  requested bank.
- bank_req_valid  in  1  qualifies bank_req.
- dim_req  in  2  requested brightness shift, 0..3.
- dim_req_valid  in  1  qualifies dim_req.
- wr_en  in  1  palette entry write strobe.
- wr_bank  in  BANK_W  bank to write.
- wr_index  in  IDX_W  entry to write.
- wr_rgb  in  3*CH_W  {R,G,B} value to write.
- red  out  CH_W  output red channel.
- green  out  CH_W  output green channel.
- blue  out  CH_W  output blue channel.
- transparent  out  1  output pixel is the key index.
- out_valid  out  1  outputs correspond to a pixel_valid input.
- active_bank  out  BANK_W  bank in use for the current frame.

Behaviour:
- Storage: NUM_BANKS x 2**IDX_W register array of 3*CH_W bits.
  - On Reset, bank 0 loads pkg DEFAULT_PAL: A/E/A, A/0/1, F/F/F, 0/0/0, F/7/6, 0/5/0; entries 6..15 are A/E/A.
  - On Reset, all other banks load 0.
- Reset outputs: red/green/blue=0, transparent=0, out_valid=0, active_bank=0, dim=0, no pending request.
- Pending request registers:
  - bank_req_valid with bank_req < NUM_BANKS sets pend_bank and pend_bank_v.
  - bank_req >= NUM_BANKS is dropped.
  - A later request overwrites an earlier one; the last one wins.
  - dim_req_valid sets pend_dim and pend_dim_v in the same way.
- On frame_start:
  - If pend_bank_v, active_bank <= pend_bank and pend_bank_v clears.
  - The same applies to dim.
  - A request arriving in the same cycle as frame_start is applied at that frame_start (bypass).
  - No pending request: nothing changes.
- Stage 1 (cycle N+1): s1_rgb <= mem[active_bank][index]; s1_t <= (index==KEY_IDX); s1_v <= pix_valid.
  - The lookup uses active_bank as registered before any frame_start update in the same cycle.
- Stage 2 (cycle N+2):
  - red/green/blue <= each s1 channel logically shifted right by the dim value captured with the stage-1 pixel.
  - transparent <= s1_t; out_valid <= s1_v.
  - Latency is exactly 2 cycles and the pipeline accepts one index per cycle.
- When pix_valid=0, the pipeline still advances: out_valid=0 and colour outputs hold don't-care lookup data; the bench does not check colour outputs while out_valid=0.
- Write port:
  - wr_en with wr_bank < NUM_BANKS updates the entry at the clock edge.
  - A write with wr_bank out of range is ignored.
  - Writing the active bank mid-frame is permitted.
  - Same-cycle write and read of the same entry returns the old value (read-before-write); the new value is visible from the next lookup on.
  - Writing KEY_IDX changes its stored colour; transparent stays 1 for that index.
- Reset asserted mid-frame or mid-pipeline:
  - Clears the pipeline, pending requests, active_bank and dim, and reloads storage the next cycle.
  - Reset has priority over every other input.

Decomposition:
- Package sprite_palette_pkg: DEFAULT_PAL constant (16 x 12-bit), an rgb_t packed struct {r,g,b}, and the KEY_IDX default.
- One sub-module, palette_frame_latch: pending/active register pair with frame_start bypass. It is instantiated twice, for bank (BANK_W) and dim (2 bits).
- Storage and the pipeline stay in the top module.

Test Plan:
- Reset, then index sequence 0,1,4 with pix_valid=1 → two cycles later outputs A/E/A with transparent=1, then A/0/1 with t=0, then F/7/6; out_valid=1 for 3 cycles.
- Write bank1 idx2=C/3/9, then bank_req=1 mid-frame, then lookup idx2 → F/F/F until frame_start; after frame_start outputs C/3/9 and active_bank=1.
- bank_req=2 then bank_req=3 before frame_start → active_bank=3. bank_req=1 in the same cycle as frame_start → active_bank=1 immediately after the pulse.
- dim_req=2 then frame_start, then lookup idx2 in bank0 → 3/3/3; dim_req=3, frame_start, lookup idx4 → 1/0/0.
- Same-cycle wr_en to bank0 idx1=5/5/5 and lookup idx1 → first output A/0/1, next lookup 5/5/5. bank_req=3 with NUM_BANKS=3 → ignored.
- Reset asserted with 2 valid pixels in flight → out_valid=0 next cycle; bank0 idx1 reads A/0/1 again; active_bank=0.
